// File: rtl/exp_sched_pkg.sv
// Shared types for the exponent job scheduler: FSM states, default width,
// requester id.
package exp_sched_pkg;

    localparam int unsigned EXP_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_EXP,
        S_RESP,
        S_LCD_WAIT,
        S_LCD_GO
    } state_t;

    // Two requesters, so the id is a single bit.
    typedef logic req_id_t;

endpackage

// File: rtl/exp_watchdog.sv
// Watchdog counter: cleared on clr_i, counts while en_i, and flags expiry once
// the count reaches LIMIT-1 (where it then parks until the next clear).
module exp_watchdog #(
    parameter int unsigned LIMIT = 1048576
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = (cnt_q == CW'(LIMIT - 1));

    // Next count: clear wins, otherwise count up and saturate at expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !expire_o)
            cnt_d = cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/exp_job_scheduler.sv
// Round-robin scheduler sharing one a^n core between two requesters. Launches
// the core, watches for completion with a watchdog, returns the result to the
// requester, then hands successful results to the LCD controller.
module exp_job_scheduler
    import exp_sched_pkg::*;
#(
    parameter int unsigned WIDTH          = EXP_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] n0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] n1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] res_o,
    output logic             err_o,
    output logic             exp_go,
    output logic [WIDTH-1:0] exp_a,
    output logic [WIDTH-1:0] exp_n,
    input  logic             exp_done,
    input  logic [WIDTH-1:0] exp_result,
    output logic             lcd_start,
    output logic [WIDTH-1:0] lcd_value,
    input  logic             lcd_busy,
    output logic             busy_o,
    output logic             timeout_err
);

    state_t           state_q, state_d;
    req_id_t          last_q, last_d;
    req_id_t          id_q, id_d;
    req_id_t          pick;
    logic [WIDTH-1:0] a_q, a_d, n_q, n_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] lcdv_q, lcdv_d;
    logic             err_q, err_d;
    logic             tmo_q, tmo_d;
    logic             wd_expire;

    exp_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wd (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (state_q == S_LAUNCH),
        .en_i     (state_q == S_WAIT_EXP),
        .expire_o (wd_expire)
    );

    // Arbitration pick: on a tie, the requester not granted last wins.
    always_comb begin
        pick = req1;
        if (req0 && req1)
            pick = ~last_q;
    end

    // Next-state and datapath latching for the job sequence.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        a_d     = a_q;
        n_d     = n_q;
        res_d   = res_q;
        lcdv_d  = lcdv_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    id_d    = pick;
                    last_d  = pick;
                    a_d     = pick ? a1 : a0;
                    n_d     = pick ? n1 : n0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT_EXP;
            S_WAIT_EXP: begin
                // A completion in the expiry cycle still counts as success.
                if (exp_done) begin
                    res_d   = exp_result;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wd_expire) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            // Timed-out jobs are reported but never displayed.
            S_RESP: state_d = err_q ? S_IDLE : S_LCD_WAIT;
            S_LCD_WAIT: begin
                if (!lcd_busy) begin
                    lcdv_d  = res_q;
                    state_d = S_LCD_GO;
                end
            end
            S_LCD_GO: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight job.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            a_q     <= '0;
            n_q     <= '0;
            res_q   <= '0;
            lcdv_q  <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            n_q     <= n_d;
            res_q   <= res_d;
            lcdv_q  <= lcdv_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Moore outputs decoded from registered state.
    assign exp_go      = (state_q == S_LAUNCH);
    assign done0       = (state_q == S_RESP) && !id_q;
    assign done1       = (state_q == S_RESP) && id_q;
    assign err_o       = (state_q == S_RESP) && err_q;
    assign res_o       = res_q;
    assign exp_a       = a_q;
    assign exp_n       = n_q;
    assign lcd_start   = (state_q == S_LCD_GO);
    assign lcd_value   = lcdv_q;
    assign busy_o      = (state_q != S_IDLE);
    assign timeout_err = tmo_q;

endmodule
